// File: rtl/tag_mem_array_responder.sv
// Tag memory responder: decodes the precharge/sense/write handshake and holds the
// EPC, sensor 1 and sensor 2 word banks with per-word valid bits.
module tag_mem_array_responder #(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        mem_sel,
  input  logic [ADDR_W-1:0] mem_address,
  input  logic              PC_B,
  input  logic              WE,
  input  logic              SE,
  input  logic [1:0]        RorW,
  input  logic [15:0]       mem_data_in,
  output logic [15:0]       mem_read_out,
  output logic              busy,
  output logic              access_done,
  output logic              err_sel,
  output logic              err_addr,
  output logic              err_proto
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StPre, StRecover} state_e;

  state_e              state_q, state_d;
  logic [1:0]          bank_q, bank_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                op_rd_q, op_rd_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [15:0]         rdata_q, rdata_d;
  logic                done_q, done_d;
  logic                err_sel_q, err_sel_d;
  logic                err_addr_q, err_addr_d;
  logic                err_proto_q, err_proto_d;
  logic                wr_en;

  logic [15:0]         mem_q   [3][DEPTH];
  logic [DEPTH-1:0]    valid_q [3];

  // Start-edge decode shared by IDLE and the re-precharge path in PRE.
  logic       op_start, sel_onehot, addr_ok, start_ok;
  logic [1:0] sel_idx;
  logic [15:0] rd_word;

  always_comb begin
    sel_idx    = 2'd0;
    sel_onehot = 1'b1;
    case (mem_sel)
      3'b001:  sel_idx = 2'd0;
      3'b010:  sel_idx = 2'd1;
      3'b100:  sel_idx = 2'd2;
      default: sel_onehot = 1'b0;
    endcase
    op_start = !PC_B && (RorW == 2'b01 || RorW == 2'b10);
    addr_ok  = 32'(mem_address) < DEPTH;
    start_ok = op_start && sel_onehot && addr_ok;
    rd_word  = '0;
    if (sel_onehot && addr_ok && valid_q[sel_idx][mem_address]) begin
      rd_word = mem_q[sel_idx][mem_address];
    end
  end

  always_comb begin
    state_d     = state_q;
    bank_d      = bank_q;
    addr_d      = addr_q;
    op_rd_d     = op_rd_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    done_d      = 1'b0;
    err_sel_d   = err_sel_q;
    err_addr_d  = err_addr_q;
    err_proto_d = err_proto_q;
    wr_en       = 1'b0;

    unique case (state_q)
      StIdle, StPre: begin
        if (!PC_B) begin
          cnt_d = '0;
          if (RorW == 2'b11) begin
            err_proto_d = 1'b1;
            state_d     = StIdle;
          end else if (op_start) begin
            if (!sel_onehot) begin
              err_sel_d = 1'b1;
              state_d   = StIdle;
            end else if (!addr_ok) begin
              err_addr_d = 1'b1;
              rdata_d    = '0;
              state_d    = StIdle;
            end
          end
          if (start_ok) begin
            bank_d  = sel_idx;
            addr_d  = mem_address;
            op_rd_d = (RorW == 2'b01);
            state_d = StPre;
            if (RorW == 2'b01) rdata_d = rd_word;
          end
        end else if (state_q == StPre) begin
          if ((WE && SE) || (WE && op_rd_q) || (SE && !op_rd_q)) begin
            err_proto_d = 1'b1;
            cnt_d       = '0;
            state_d     = StIdle;
          end else if (WE || SE) begin
            // Legal strobe for the latched op; write commits on this edge.
            wr_en   = WE;
            done_d  = 1'b1;
            cnt_d   = '0;
            state_d = StRecover;
          end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
            err_proto_d = 1'b1;
            cnt_d       = '0;
            state_d     = StIdle;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StRecover: begin
        if (!WE && !SE && RorW == 2'b00) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      bank_q      <= '0;
      addr_q      <= '0;
      op_rd_q     <= 1'b0;
      cnt_q       <= '0;
      rdata_q     <= '0;
      done_q      <= 1'b0;
      err_sel_q   <= 1'b0;
      err_addr_q  <= 1'b0;
      err_proto_q <= 1'b0;
      for (int b = 0; b < 3; b++) valid_q[b] <= '0;
    end else begin
      state_q     <= state_d;
      bank_q      <= bank_d;
      addr_q      <= addr_d;
      op_rd_q     <= op_rd_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      done_q      <= done_d;
      err_sel_q   <= err_sel_d;
      err_addr_q  <= err_addr_d;
      err_proto_q <= err_proto_d;
      if (wr_en) valid_q[bank_q][addr_q] <= 1'b1;
    end
  end

  // Array contents survive reset; only the valid bits are cleared.
  always_ff @(posedge clk) begin
    if (reset_n && wr_en) mem_q[bank_q][addr_q] <= mem_data_in;
  end

  assign mem_read_out = rdata_q;
  assign busy         = (state_q != StIdle);
  assign access_done  = done_q;
  assign err_sel      = err_sel_q;
  assign err_addr     = err_addr_q;
  assign err_proto    = err_proto_q;

endmodule

// File: tb/tb_tag_mem_array_responder.sv
// Bench for tag_mem_array_responder: table of write/read vectors, hand-written
// error/reset/timeout sequences, and random accesses against a word-map model.
module tb_tag_mem_array_responder;

  localparam int unsigned DEPTH   = 48;
  localparam int unsigned ADDR_W  = 6;
  localparam int unsigned TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [2:0]        mem_sel;
  logic [ADDR_W-1:0] mem_address;
  logic              PC_B, WE, SE;
  logic [1:0]        RorW;
  logic [15:0]       mem_data_in;
  logic [15:0]       mem_read_out;
  logic              busy, access_done, err_sel, err_addr, err_proto;

  int checks = 0;
  int errors = 0;

  // Reference: map from (bank, address) to last written word; absent means unwritten.
  logic [15:0] model [int];

  tag_mem_array_responder #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .mem_sel(mem_sel), .mem_address(mem_address),
    .PC_B(PC_B), .WE(WE), .SE(SE), .RorW(RorW), .mem_data_in(mem_data_in),
    .mem_read_out(mem_read_out), .busy(busy), .access_done(access_done),
    .err_sel(err_sel), .err_addr(err_addr), .err_proto(err_proto)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [2:0]  sel;
    logic [5:0]  addr;
    logic [15:0] data;
  } vec_t;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    PC_B = 1'b1; WE = 1'b0; SE = 1'b0; RorW = 2'b00;
  endtask

  function automatic int key(input logic [2:0] sel, input logic [5:0] addr);
    int b;
    b = (sel == 3'b001) ? 0 : (sel == 3'b010) ? 1 : 2;
    return b * 64 + int'(addr);
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    idle_in();
    step();
    reset_n = 1'b1;
    model.delete();
  endtask

  task automatic wr(input logic [2:0] sel, input logic [5:0] addr, input logic [15:0] data,
                    output int dones);
    dones = 0;
    mem_sel = sel; mem_address = addr; mem_data_in = data;
    PC_B = 1'b0; RorW = 2'b10; step(); dones += int'(access_done);
    PC_B = 1'b1; WE = 1'b1;    step(); dones += int'(access_done);
    WE = 1'b0; RorW = 2'b00;   step(); dones += int'(access_done);
  endtask

  task automatic rd(input logic [2:0] sel, input logic [5:0] addr, output logic [15:0] data,
                    output int dones, output logic busy_after);
    dones = 0;
    mem_sel = sel; mem_address = addr;
    PC_B = 1'b0; RorW = 2'b01; step(); dones += int'(access_done);
    data = mem_read_out;
    PC_B = 1'b1; SE = 1'b1;    step(); dones += int'(access_done);
    SE = 1'b0; RorW = 2'b00;   step(); dones += int'(access_done);
    busy_after = busy;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t        tbl [7];
    logic [15:0] rdat;
    logic        bz;
    int          dn;

    tbl[0] = '{1'b1, 3'b001, 6'd5, 16'hA5C3};
    tbl[1] = '{1'b1, 3'b010, 6'd0, 16'h1234};
    tbl[2] = '{1'b1, 3'b100, 6'd0, 16'h5678};
    tbl[3] = '{1'b0, 3'b001, 6'd5, 16'hA5C3};
    tbl[4] = '{1'b0, 3'b001, 6'd0, 16'h0000};
    tbl[5] = '{1'b0, 3'b010, 6'd0, 16'h1234};
    tbl[6] = '{1'b0, 3'b100, 6'd0, 16'h5678};

    mem_sel = 3'b001; mem_address = '0; mem_data_in = '0;
    idle_in();
    reset_n = 1'b0;
    step(); step();
    reset_n = 1'b1;
    chk("reset read_out", mem_read_out, 16'h0000);
    chk("reset busy", 16'(busy), 16'h0);
    chk("reset done", 16'(access_done), 16'h0);
    chk("reset errs", 16'({err_sel, err_addr, err_proto}), 16'h0);

    for (int i = 0; i < 7; i++) begin
      if (tbl[i].wr) begin
        wr(tbl[i].sel, tbl[i].addr, tbl[i].data, dn);
        chk($sformatf("vec%0d write done count", i), 16'(dn), 16'd1);
      end else begin
        rd(tbl[i].sel, tbl[i].addr, rdat, dn, bz);
        chk($sformatf("vec%0d read data", i), rdat, tbl[i].data);
        chk($sformatf("vec%0d read hold", i), mem_read_out, tbl[i].data);
        chk($sformatf("vec%0d read done count", i), 16'(dn), 16'd1);
      end
    end

    // Out-of-range address clears the read register.
    mem_sel = 3'b001; mem_address = 6'd63; PC_B = 1'b0; RorW = 2'b01;
    step();
    chk("err_addr flag", 16'(err_addr), 16'h1);
    chk("err_addr read_out", mem_read_out, 16'h0000);
    chk("err_addr busy", 16'(busy), 16'h0);
    chk("err_addr no err_sel", 16'(err_sel), 16'h0);

    mem_sel = 3'b011; mem_address = 6'd1; RorW = 2'b10;
    step();
    chk("err_sel flag", 16'(err_sel), 16'h1);
    chk("err_sel busy", 16'(busy), 16'h0);

    mem_sel = 3'b001; RorW = 2'b11;
    step();
    chk("rorw11 err_proto", 16'(err_proto), 16'h1);
    chk("rorw11 busy", 16'(busy), 16'h0);
    idle_in();
    step();
    chk("errs sticky", 16'({err_sel, err_addr, err_proto}), 16'h7);

    do_reset();
    chk("errs cleared", 16'({err_sel, err_addr, err_proto}), 16'h0);

    // Read op followed by WE: protocol error, no write.
    wr(3'b001, 6'd7, 16'hBEEF, dn);
    mem_sel = 3'b001; mem_address = 6'd7; PC_B = 1'b0; RorW = 2'b01;
    step();
    PC_B = 1'b1; WE = 1'b1; mem_data_in = 16'hDEAD;
    step();
    chk("viol err_proto", 16'(err_proto), 16'h1);
    chk("viol busy", 16'(busy), 16'h0);
    chk("viol done", 16'(access_done), 16'h0);
    idle_in();
    step();
    rd(3'b001, 6'd7, rdat, dn, bz);
    chk("viol no write", rdat, 16'hBEEF);

    // PRE held with PC_B=1 and no strobe times out on the 8th cycle.
    do_reset();
    mem_sel = 3'b010; mem_address = 6'd4; PC_B = 1'b0; RorW = 2'b01;
    step();
    PC_B = 1'b1;
    for (int i = 0; i < TIMEOUT - 1; i++) step();
    chk("timeout cycle7 busy", 16'(busy), 16'h1);
    chk("timeout cycle7 err", 16'(err_proto), 16'h0);
    step();
    chk("timeout cycle8 busy", 16'(busy), 16'h0);
    chk("timeout cycle8 err", 16'(err_proto), 16'h1);
    idle_in();
    step();

    // Reset on the WE edge of a write must abort it.
    do_reset();
    wr(3'b001, 6'd2, 16'h1111, dn);
    rd(3'b001, 6'd2, rdat, dn, bz);
    chk("pre-reset word", rdat, 16'h1111);
    mem_address = 6'd2; mem_data_in = 16'h2222; PC_B = 1'b0; RorW = 2'b10;
    step();
    PC_B = 1'b1; WE = 1'b1; reset_n = 1'b0;
    step();
    chk("midrst busy", 16'(busy), 16'h0);
    chk("midrst done", 16'(access_done), 16'h0);
    chk("midrst read_out", mem_read_out, 16'h0000);
    chk("midrst errs", 16'({err_sel, err_addr, err_proto}), 16'h0);
    reset_n = 1'b1;
    model.delete();
    idle_in();
    step();
    rd(3'b001, 6'd2, rdat, dn, bz);
    chk("midrst word invalid", rdat, 16'h0000);

    // Back-to-back reads at the master's cadence.
    wr(3'b001, 6'd3, 16'h3333, dn);
    wr(3'b001, 6'd2, 16'h2C2C, dn);
    rd(3'b001, 6'd3, rdat, dn, bz);
    chk("b2b first data", rdat, 16'h3333);
    chk("b2b first busy gap", 16'(bz), 16'h0);
    rd(3'b001, 6'd2, rdat, dn, bz);
    chk("b2b second data", rdat, 16'h2C2C);
    chk("b2b second busy gap", 16'(bz), 16'h0);
    model[key(3'b001, 6'd3)] = 16'h3333;
    model[key(3'b001, 6'd2)] = 16'h2C2C;

    for (int i = 0; i < 60; i++) begin
      logic [2:0]  s;
      logic [5:0]  a;
      logic [15:0] d;
      logic [15:0] exp;
      s = 3'b001 << $urandom_range(0, 2);
      a = ($urandom_range(0, 1) != 0) ? 6'($urandom_range(0, DEPTH - 1))
                                      : 6'($urandom_range(0, 3));
      if ($urandom_range(0, 1) != 0) begin
        d = 16'($urandom);
        wr(s, a, d, dn);
        model[key(s, a)] = d;
        chk($sformatf("rand%0d write done", i), 16'(dn), 16'd1);
      end else begin
        exp = model.exists(key(s, a)) ? model[key(s, a)] : 16'h0000;
        rd(s, a, rdat, dn, bz);
        chk($sformatf("rand%0d read sel=%b addr=%0d", i, s, a), rdat, exp);
        chk($sformatf("rand%0d read done", i), 16'(dn), 16'd1);
      end
    end
    chk("rand no errs", 16'({err_sel, err_addr, err_proto}), 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
